// File: rtl/scrambler_pkg.sv
// Shared types and constants for the 802.11 scrambler frame sequencer.
// Holds the FSM state encoding, the all-ones seed substitute, the default
// SERVICE/TAIL lengths and the counter width used for those phases.
package scrambler_pkg;

    // Frame phases, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SERVICE = 3'd2,
        DATA    = 3'd3,
        TAIL    = 3'd4,
        DONE    = 3'd5
    } state_e;

    // A zero seed would lock the scrambler LFSR at zero, so it is replaced.
    localparam logic [6:0] SEED_ALL_ONES = 7'h7F;

    localparam int LEN_W_DEF        = 12;
    localparam int SERVICE_BITS_DEF = 16;
    localparam int TAIL_BITS_DEF    = 6;

    // Wide enough to count either SERVICE or TAIL cycles.
    localparam int CNT_W = 5;

    // Seed actually presented to the scrambler for a requested seed.
    function automatic logic [6:0] eff_seed(input logic [6:0] s);
        return (s == 7'd0) ? SEED_ALL_ONES : s;
    endfunction

endpackage

// File: rtl/scrambler_seq_if.sv
// Bundle of the frame-request, byte-stream and scrambler-side signals.
// byte_valid/byte_ready: a byte moves on a rising edge where both are high;
// byte_valid without byte_ready is simply ignored and the source keeps the
// byte; byte_ready never depends combinationally on byte_valid.
// slave is the sequencer side, master is the side driving frames and bytes.
interface scrambler_seq_if #(
    parameter int LEN_W = 12
);
    import scrambler_pkg::*;

    logic             start;
    logic [6:0]       seed;
    logic [LEN_W-1:0] len;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             scr_load;
    logic [6:0]       scr_seed;
    logic             scr_enable;
    logic             scr_bit;
    logic             tail_zero;
    logic             busy;
    logic             done;
    logic             underrun;
    state_e           state_dbg;

    modport slave (
        input  start, seed, len, byte_data, byte_valid,
        output byte_ready, scr_load, scr_seed, scr_enable, scr_bit,
               tail_zero, busy, done, underrun, state_dbg
    );

    modport master (
        output start, seed, len, byte_data, byte_valid,
        input  byte_ready, scr_load, scr_seed, scr_enable, scr_bit,
               tail_zero, busy, done, underrun, state_dbg
    );

endinterface

// File: rtl/bit_serializer.sv
// 8-bit LSB-first shift register feeding the scrambler one bit per clock.
// load takes priority over shift so a new byte can replace the last bit of
// the previous one on the same edge. Zeros are shifted in, so once a byte is
// fully sent bit_out stays 0 until the next load; empty marks that condition.
module bit_serializer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] byte_in,
    output logic       bit_out,
    output logic [2:0] bit_idx,
    output logic       empty
);
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       empty_q, empty_d;

    // Next shift-register contents, bit position and empty flag.
    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        empty_d   = empty_q;
        if (load) begin
            shreg_d   = byte_in;
            bit_idx_d = 3'd0;
            empty_d   = 1'b0;
        end else if (shift) begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
                empty_d = 1'b1;
            end
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            empty_q   <= 1'b1;
        end else begin
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            empty_q   <= empty_d;
        end
    end

    assign bit_out = shreg_q[0];
    assign bit_idx = bit_idx_q;
    assign empty   = empty_q;

endmodule

// File: rtl/scrambler_seq.sv
// Frame sequencer for the 802.11 scrambler: seed load, SERVICE zeros,
// LSB-first PSDU bits, TAIL zeros, then a one-cycle done pulse.
// Byte starvation stalls the stream (scr_enable low) without losing bits and
// sets the sticky underrun flag.
// Optional feature macro: SCRAMBLER_SEQ_TAILZERO_EN drives tail_zero high
// during TAIL; without it tail_zero is held at 0.
module scrambler_seq
    import scrambler_pkg::*;
#(
    parameter int LEN_W        = LEN_W_DEF,
    parameter int SERVICE_BITS = SERVICE_BITS_DEF,
    parameter int TAIL_BITS    = TAIL_BITS_DEF
) (
    input  logic           clock,
    input  logic           reset,
    scrambler_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] SERVICE_LAST = CNT_W'(SERVICE_BITS - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST    = CNT_W'(TAIL_BITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic             underrun_q, underrun_d;
    logic             byte_ready_q, byte_ready_d;
    logic             scr_load_q, scr_load_d;
    logic [6:0]       scr_seed_q, scr_seed_d;
    logic             scr_enable_q, scr_enable_d;
    logic             tail_zero_q, tail_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             stall_d;
    logic             accept;
    logic             ser_load;
    logic             ser_shift;
    logic             ser_bit;
    logic             ser_empty;
    logic [2:0]       ser_idx;

    bit_serializer u_ser (
        .clock   (clock),
        .reset   (reset),
        .load    (ser_load),
        .shift   (ser_shift),
        .byte_in (bus.byte_data),
        .bit_out (ser_bit),
        .bit_idx (ser_idx),
        .empty   (ser_empty)
    );

    // Phase sequencing, byte acceptance and starvation detection.
    // Inside DATA an empty serializer means the stream is stalled waiting on
    // a byte; the bit position is therefore implicitly held.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bytes_left_d = bytes_left_q;
        underrun_d   = underrun_q;
        stall_d      = 1'b0;
        ser_load     = 1'b0;
        ser_shift    = 1'b0;
        accept       = byte_ready_q & bus.byte_valid;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = LOAD;
                    bytes_left_d = bus.len;
                    underrun_d   = 1'b0;
                end
            end
            LOAD: begin
                state_d = SERVICE;
                cnt_d   = '0;
            end
            SERVICE: begin
                if (cnt_q == SERVICE_LAST) begin
                    cnt_d = '0;
                    if (bytes_left_q == '0) begin
                        state_d = TAIL;
                    end else begin
                        state_d = DATA;
                        if (accept) begin
                            ser_load = 1'b1;
                        end else begin
                            stall_d    = 1'b1;
                            underrun_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (ser_empty) begin
                    // Stalled: resume on the cycle after a byte arrives.
                    if (accept) begin
                        ser_load = 1'b1;
                    end else begin
                        stall_d = 1'b1;
                    end
                end else begin
                    ser_shift = 1'b1;
                    if (ser_idx == 3'd7) begin
                        bytes_left_d = bytes_left_q - LEN_W'(1);
                        if (bytes_left_q == LEN_W'(1)) begin
                            state_d = TAIL;
                            cnt_d   = '0;
                        end else if (accept) begin
                            ser_load = 1'b1;
                        end else begin
                            stall_d    = 1'b1;
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the phase being entered next cycle.
    always_comb begin
        scr_load_d   = (state_d == LOAD);
        scr_seed_d   = (state_d == LOAD) ? eff_seed(bus.seed) : 7'd0;
        scr_enable_d = (state_d == SERVICE) || (state_d == TAIL) ||
                       ((state_d == DATA) && !stall_d);
`ifdef SCRAMBLER_SEQ_TAILZERO_EN
        tail_zero_d  = (state_d == TAIL);
`else
        tail_zero_d  = 1'b0;
`endif
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        // Ready for the first byte in the last SERVICE cycle, for the next
        // byte while bit 7 is going out, and throughout a stall.
        byte_ready_d = stall_d ||
                       ((state_d == SERVICE) && (cnt_d == SERVICE_LAST) &&
                        (bytes_left_d != '0)) ||
                       ((state_q == DATA) && !ser_empty && (ser_idx == 3'd6) &&
                        (bytes_left_q > LEN_W'(1)));
    end

    // State, counters and output registers; reset wins over everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bytes_left_q <= '0;
            underrun_q   <= 1'b0;
            byte_ready_q <= 1'b0;
            scr_load_q   <= 1'b0;
            scr_seed_q   <= 7'd0;
            scr_enable_q <= 1'b0;
            tail_zero_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bytes_left_q <= bytes_left_d;
            underrun_q   <= underrun_d;
            byte_ready_q <= byte_ready_d;
            scr_load_q   <= scr_load_d;
            scr_seed_q   <= scr_seed_d;
            scr_enable_q <= scr_enable_d;
            tail_zero_q  <= tail_zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.scr_load   = scr_load_q;
    assign bus.scr_seed   = scr_seed_q;
    assign bus.scr_enable = scr_enable_q;
    // The serializer only holds non-zero bits while DATA bits are going out,
    // so its output is zero in every other phase and during stalls.
    assign bus.scr_bit    = ser_bit;
    assign bus.tail_zero  = tail_zero_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_scrambler_seq.sv
// Self-checking bench for scrambler_seq: directed frames, expected events
// queued at issue time and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_scrambler_seq;
    import scrambler_pkg::*;

    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_BIT  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
`ifdef SCRAMBLER_SEQ_TAILZERO_EN
    localparam int EXP_TZ = 6;
`else
    localparam int EXP_TZ = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    scrambler_seq_if bus ();

    scrambler_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [9:0]  exp_q[$];     // {kind, data}
    logic [11:0] byte_src[$];  // {gap before offering, byte}
    int checks      = 0;
    int errors      = 0;
    int done_seen   = 0;
    int done_target = 0;
    int lat         = 0;
    int tz_cnt      = 0;
    int rdy_cnt     = 0;
    int ev_idx      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_event(input logic [1:0] kind, input logic [7:0] data, input string name);
        logic [9:0] e;
        ev_idx++;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s#%0d: got unexpected event %0h expected none", name, ev_idx, {kind, data});
        end else begin
            e = exp_q.pop_front();
            check($sformatf("%s#%0d", name, ev_idx), {22'd0, kind, data}, {22'd0, e});
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (bus.scr_load) begin
                lat     = 0;
                tz_cnt  = 0;
                rdy_cnt = 0;
                check_event(K_LOAD, {1'b0, bus.scr_seed}, "load_seed");
            end else begin
                lat++;
            end
            if (bus.tail_zero) tz_cnt++;
            if (bus.byte_ready) rdy_cnt++;
            if (bus.scr_enable) check_event(K_BIT, {7'd0, bus.scr_bit}, "bit");
            if (bus.done) begin
                check_event(K_DONE, {bus.underrun, lat[6:0]}, "done_unr_lat");
                check("tail_zero_cycles", tz_cnt, EXP_TZ);
                done_seen++;
            end
        end
    end

    // ---------------- byte source driver ----------------
    bit drv_took  = 1'b0;
    bit drv_fresh = 1'b1;
    int drv_gap   = 0;

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                byte_src.delete();
                drv_fresh      = 1'b1;
                drv_took       = 1'b0;
                drv_gap        = 0;
                bus.byte_valid = 1'b0;
            end else begin
                if (drv_took) begin
                    void'(byte_src.pop_front());
                    drv_fresh = 1'b1;
                end
                if (byte_src.size() > 0 && drv_fresh) begin
                    drv_gap   = int'(byte_src[0][11:8]);
                    drv_fresh = 1'b0;
                end
                if (byte_src.size() > 0 && drv_gap == 0) begin
                    bus.byte_valid = 1'b1;
                    bus.byte_data  = byte_src[0][7:0];
                end else begin
                    bus.byte_valid = 1'b0;
                    // Each withheld cycle with ready high is one starved edge.
                    if (byte_src.size() > 0 && bus.byte_ready && drv_gap > 0) drv_gap--;
                end
                drv_took = bus.byte_valid && bus.byte_ready;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_frame(input logic [6:0] sd, input logic [6:0] exp_seed, input int n,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [3:0] gap2, input logic [6:0] exp_lat,
                               input logic exp_unr);
        logic [7:0] bb[3];
        int t;
        bb[0] = b0;
        bb[1] = b1;
        bb[2] = b2;
        t = 0;
        while (bus.busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("idle_before_start", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back({K_LOAD, 1'b0, exp_seed});
        for (int i = 0; i < 16; i++) exp_q.push_back({K_BIT, 8'd0});
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++) exp_q.push_back({K_BIT, 7'd0, bb[i][k]});
        for (int i = 0; i < 6; i++) exp_q.push_back({K_BIT, 8'd0});
        exp_q.push_back({K_DONE, exp_unr, exp_lat});
        for (int i = 0; i < n; i++) byte_src.push_back({(i == 2) ? gap2 : 4'd0, bb[i]});
        bus.start = 1'b1;
        bus.seed  = sd;
        bus.len   = 12'(n);
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_rdy);
        int t;
        t = 0;
        done_target++;
        while (done_seen < done_target && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (done_seen < done_target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, t);
            done_target = done_seen;
        end else begin
            check({name, "_ready_cycles"}, rdy_cnt, exp_rdy);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200us");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.start = 1'b0;
        bus.seed  = 7'd0;
        bus.len   = 12'd0;
        reset     = 1'b0;

        // Reset held low while start is requested: reset wins.
        @(negedge clock);
        bus.start = 1'b1;
        bus.seed  = 7'h5D;
        bus.len   = 12'd1;
        repeat (2) @(negedge clock);
        check("rst_busy",       {31'd0, bus.busy}, 32'd0);
        check("rst_state",      32'(bus.state_dbg), 32'(IDLE));
        check("rst_scr_load",   {31'd0, bus.scr_load}, 32'd0);
        check("rst_scr_enable", {31'd0, bus.scr_enable}, 32'd0);
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_done",       {31'd0, bus.done}, 32'd0);
        check("rst_underrun",   {31'd0, bus.underrun}, 32'd0);
        check("rst_seed",       {25'd0, bus.scr_seed}, 32'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clock);

        // 1: seed 5D, one byte A5 -> bits 1,0,1,0,0,1,0,1, done 31 after LOAD.
        issue_frame(7'h5D, 7'h5D, 1, 8'hA5, 8'h00, 8'h00, 4'd0, 7'd31, 1'b0);
        wait_done("t1", 1);

        // 2: zero seed is replaced by all ones.
        issue_frame(7'h00, 7'h7F, 1, 8'h3C, 8'h00, 8'h00, 4'd0, 7'd31, 1'b0);
        wait_done("t2", 1);

        // 3: empty PSDU -> 22 zero bits, no byte_ready, done 23 after LOAD.
        issue_frame(7'h2A, 7'h2A, 0, 8'h00, 8'h00, 8'h00, 4'd0, 7'd23, 1'b0);
        wait_done("t3", 0);

        // 4: third byte withheld for 4 request edges -> 4 stall cycles.
        issue_frame(7'h33, 7'h33, 3, 8'hC3, 8'h5A, 8'h96, 4'd4, 7'd51, 1'b1);
        wait_done("t4", 7);
        @(negedge clock);
        check("t4_underrun_sticky", {31'd0, bus.underrun}, 32'd1);

        // 6: start pulsed during SERVICE is ignored; underrun cleared by start.
        issue_frame(7'h41, 7'h41, 2, 8'hF0, 8'h0F, 8'h00, 4'd0, 7'd39, 1'b0);
        repeat (4) @(negedge clock);
        check("t6_busy_in_service", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        bus.seed  = 7'h11;
        bus.len   = 12'd7;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done("t6", 2);

        // 5: reset mid-DATA, then a fresh normal frame.
        issue_frame(7'h12, 7'h12, 2, 8'h81, 8'h7E, 8'h00, 4'd0, 7'd39, 1'b0);
        repeat (20) @(negedge clock);
        check("t5_in_data", 32'(bus.state_dbg), 32'(DATA));
        reset = 1'b0;
        @(negedge clock);
        check("t5_rst_state",      32'(bus.state_dbg), 32'(IDLE));
        check("t5_rst_busy",       {31'd0, bus.busy}, 32'd0);
        check("t5_rst_scr_enable", {31'd0, bus.scr_enable}, 32'd0);
        check("t5_rst_scr_bit",    {31'd0, bus.scr_bit}, 32'd0);
        check("t5_rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        exp_q.delete();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        issue_frame(7'h5D, 7'h5D, 1, 8'hA5, 8'h00, 8'h00, 4'd0, 7'd31, 1'b0);
        wait_done("t5_fresh", 1);

        repeat (5) @(negedge clock);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
